// File: rtl/counter_pkg.sv
// Shared definitions for the counter-driven PWM block.
//   CNT_W_DEF : default width of the count input and duty value
//   state_e   : duty-load FSM states (IDLE = no shadow pending, PEND = shadow holds a duty)
//   cnt_max() : all-ones count value for a given width (the wrap-from value)
package counter_pkg;

  localparam int unsigned CNT_W_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_e;

  function automatic logic [31:0] cnt_max(input int unsigned w);
    cnt_max = (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/count_wrap_det.sv
// Wrap detector for a free-running up-counter.
// A wrap is reported only on the transition all-ones -> zero, seen as
// registered previous count = 2^CNT_W-1 and current count = 0.
//   clk   : clock, rising edge
//   reset : synchronous, active-high; clears the previous-count register
//   count : current counter value
//   wrap  : combinational, high during the cycle the count reads 0 after all-ones
module count_wrap_det
  import counter_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] count,
  output logic             wrap
);

  logic [CNT_W-1:0] prev_q;

  // Clearing to zero (not all-ones) means no tick can fire until the
  // counter has actually been observed at its maximum after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= '0;
    end else begin
      prev_q <= count;
    end
  end

  assign wrap = (prev_q == '1) && (count == '0);

endmodule

// File: rtl/counter_pwm.sv
// PWM generator driven by an external free-running counter.
// A new duty is accepted through a valid/ready handshake into a shadow
// register and transferred to the active register on the next count wrap,
// so each period is generated with a single, consistent duty value.
//   clk         : clock, rising edge
//   reset       : synchronous, active-high
//   count       : upstream up-count, wraps 2^CNT_W-1 -> 0
//   en          : output enable; 0 forces pwm inactive
//   duty        : requested duty, qualified by duty_valid
//   duty_valid  : duty-load request
//   duty_ready  : high when no duty is pending (a new one can be accepted)
//   pwm         : registered waveform, active level POL while count < active duty
//   period_tick : registered one-cycle pulse the cycle after each wrap
module counter_pwm
  import counter_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter logic        POL   = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] count,
  input  logic             en,
  input  logic [CNT_W-1:0] duty,
  input  logic             duty_valid,
  output logic             duty_ready,
  output logic             pwm,
  output logic             period_tick
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] active_q, active_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             pwm_q, pwm_d;
  logic             tick_q;
  logic             wrap;

  count_wrap_det #(
    .CNT_W(CNT_W)
  ) u_wrap (
    .clk  (clk),
    .reset(reset),
    .count(count),
    .wrap (wrap)
  );

  // A handshake accepted in IDLE on a wrap cycle only fills the shadow;
  // the transfer to active waits for the next wrap seen from PEND.
  always_comb begin
    state_d    = state_q;
    active_d   = active_q;
    shadow_d   = shadow_q;
    duty_ready = (state_q == IDLE);
    unique case (state_q)
      IDLE: begin
        if (duty_valid) begin
          shadow_d = duty;
          state_d  = PEND;
        end
      end
      PEND: begin
        if (wrap) begin
          active_d = shadow_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Plain unsigned compare: active = 0 never asserts, all-ones asserts
  // for every count except all-ones.
  always_comb begin
    pwm_d = ~POL;
    if (en && (count < active_q)) begin
      pwm_d = POL;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      active_q <= '0;
      shadow_q <= '0;
      pwm_q    <= ~POL;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      shadow_q <= shadow_d;
      pwm_q    <= pwm_d;
      tick_q   <= wrap;
    end
  end

  assign pwm         = pwm_q;
  assign period_tick = tick_q;

endmodule

// File: tb/tb_counter_pwm.sv
module tb_counter_pwm;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] count;
  logic         en;
  logic [W-1:0] duty;
  logic         duty_valid;
  logic         ready_h, pwm_h, tick_h;
  logic         ready_l, pwm_l, tick_l;

  always #5 clk = ~clk;

  counter_pwm #(.CNT_W(W), .POL(1'b1)) dut_h (
    .clk(clk), .reset(reset), .count(count), .en(en), .duty(duty),
    .duty_valid(duty_valid), .duty_ready(ready_h), .pwm(pwm_h), .period_tick(tick_h)
  );

  counter_pwm #(.CNT_W(W), .POL(1'b0)) dut_l (
    .clk(clk), .reset(reset), .count(count), .en(en), .duty(duty),
    .duty_valid(duty_valid), .duty_ready(ready_l), .pwm(pwm_l), .period_tick(tick_l)
  );

  typedef struct packed {
    logic pwm_h;
    logic pwm_l;
    logic tick;
    logic ready;
  } exp_t;

  exp_t q_exp[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  // Reference model: what the duty logic means, not how it is built.
  int   m_last_count;   // last count seen since reset, -1 = none yet
  int   m_duty;         // duty governing the current period
  int   m_pending;      // queued duty, -1 = nothing queued
  int   cnt = 0;        // upstream counter value driven next

  // Apply one cycle of inputs and predict the outputs after the next edge.
  task automatic step(input logic r, input logic e, input int d, input logic dv);
    exp_t x;
    bit   is_wrap;
    reset      = r;
    count      = cnt[W-1:0];
    en         = e;
    duty       = d[W-1:0];
    duty_valid = dv;
    if (r) begin
      x.pwm_h = 1'b0;
      x.tick  = 1'b0;
      m_last_count = -1;
      m_duty       = 0;
      m_pending    = -1;
    end else begin
      is_wrap = (m_last_count == 255) && (cnt == 0);
      x.pwm_h = e && (cnt < m_duty);
      x.tick  = is_wrap;
      if (m_pending >= 0) begin
        if (is_wrap) begin
          m_duty    = m_pending;
          m_pending = -1;
        end
      end else if (dv) begin
        m_pending = d;
      end
      m_last_count = cnt;
    end
    x.pwm_l = ~x.pwm_h;
    x.ready = (m_pending < 0);
    q_exp.push_back(x);
    @(negedge clk);
  endtask

  task automatic tick_on(input logic e, input int d, input logic dv);
    step(1'b0, e, d, dv);
    cnt = (cnt + 1) % 256;
  endtask

  // Free-run the counter (no load) until it reaches target.
  task automatic run_to(input int target, input logic e);
    for (int i = 0; i < 256 && cnt != target; i++) tick_on(e, 0, 1'b0);
  endtask

  // Monitor: outputs are valid every cycle, checked shortly after each edge.
  initial begin
    exp_t x;
    exp_t a;
    forever begin
      @(posedge clk);
      #2;
      if (q_exp.size() > 0) begin
        x = q_exp.pop_front();
        a = '{pwm_h: pwm_h, pwm_l: pwm_l, tick: tick_h, ready: ready_h};
        n_vec++;
        if (a !== x || tick_l !== x.tick || ready_l !== x.ready) begin
          n_fail++;
          $display("FAIL outputs t=%0t count_prev=%0d: got pwm_h=%b pwm_l=%b tick=%b/%b ready=%b/%b, expected pwm_h=%b pwm_l=%b tick=%b ready=%b",
                   $time, count, pwm_h, pwm_l, tick_h, tick_l, ready_h, ready_l,
                   x.pwm_h, x.pwm_l, x.tick, x.ready);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; count = '0; en = 1'b0; duty = '0; duty_valid = 1'b0;
    @(negedge clk);

    // Reset, then idle for over two periods.
    step(1'b1, 1'b1, 0, 1'b0);
    step(1'b1, 1'b1, 0, 1'b0);
    cnt = 0;
    for (int i = 0; i < 600; i++) tick_on(1'b1, 0, 1'b0);

    // Mid-period load of 64, applied at the next wrap.
    run_to(100, 1'b1);
    tick_on(1'b1, 64, 1'b1);
    for (int i = 0; i < 600; i++) tick_on(1'b1, 0, 1'b0);

    // Handshake on the wrap cycle: 128 waits one more period.
    run_to(0, 1'b1);
    tick_on(1'b1, 128, 1'b1);
    for (int i = 0; i < 600; i++) tick_on(1'b1, 0, 1'b0);

    // Load 50, then 200 while pending is ignored.
    run_to(10, 1'b1);
    tick_on(1'b1, 50, 1'b1);
    run_to(20, 1'b1);
    tick_on(1'b1, 200, 1'b1);
    for (int i = 0; i < 400; i++) tick_on(1'b1, 0, 1'b0);

    // Reset while 32 is pending: pending value is lost.
    run_to(40, 1'b1);
    tick_on(1'b1, 32, 1'b1);
    step(1'b1, 1'b1, 0, 1'b0);
    cnt = (cnt + 1) % 256;
    for (int i = 0; i < 600; i++) tick_on(1'b1, 0, 1'b0);

    // Full-scale duty 255, then enable dropped for 10 cycles.
    run_to(5, 1'b1);
    tick_on(1'b1, 255, 1'b1);
    for (int i = 0; i < 300; i++) tick_on(1'b1, 0, 1'b0);
    run_to(100, 1'b1);
    for (int i = 0; i < 10; i++) tick_on(1'b0, 0, 1'b0);
    for (int i = 0; i < 300; i++) tick_on(1'b1, 0, 1'b0);

    // Random traffic, including count jumps that must not look like wraps.
    for (int i = 0; i < 4000; i++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      if (r < 2) cnt = $urandom_range(0, 255);
      else if (r < 4) cnt = 0;
      if ($urandom_range(0, 199) == 0) begin
        step(1'b1, 1'b1, 0, 1'b0);
        cnt = (cnt + 1) % 256;
      end else begin
        tick_on($urandom_range(0, 19) != 0, $urandom_range(0, 255),
                $urandom_range(0, 29) == 0);
      end
    end

    duty_valid = 1'b0;
    repeat (3) @(negedge clk);
    if (q_exp.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected responses never checked, required 0", q_exp.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
